rr_grant_indexer: RTL
=====================

Name: rr_grant_indexer

Overview:
- Round-robin arbiter stage that sits directly upstream of the binary-to-one-hot decoder.
- Accepts up to 2**N request lines and selects one requester fairly.
- Presents the winner as a registered N-bit binary index, qualified by a valid flag; the decoder expands it into one-hot select lines.
- Holds each grant until the owner signals done, the owner withdraws, or a watchdog timeout expires.

Parameters:
- N, 2, index width; number of requesters is 2**N (N >= 1).
- TIMEOUT, 16, maximum cycles a grant may be held before forced release (>= 2).
- CW, $clog2(TIMEOUT+1), hold-counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- req  input  2**N  request lines; bit k = requester k.
- done  input  1  owner's completion pulse; sampled only while grant_valid=1.
- grant_idx  output  N  registered binary index of the current owner; feeds the decoder input.
- grant_valid  output  1  grant_idx is meaningful; downstream gates the decoder outputs with it.
- timeout  output  1  one-cycle pulse when a grant is force-released by the watchdog.

Behaviour:
- Reset (async assert, rst_n=0):
  - grant_idx=0, grant_valid=0, timeout=0.
  - FSM=IDLE, round-robin pointer ptr=0, hold counter=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from ptr, wrapping modulo 2**N.
  - Register the winner into grant_idx, set grant_valid=1, clear the counter, go to GRANT.
  - Latency: req sampled at edge t gives grant_valid=1 after edge t.
  - If req=0, stay in IDLE; grant_idx keeps its last value.
- GRANT: the counter increments each cycle, saturating at TIMEOUT. Release occurs on the first of:
  - (a) done=1;
  - (b) req[grant_idx]=0 (owner withdrawal);
  - (c) counter reaches TIMEOUT-1 without (a) or (b).
- On release:
  - ptr = grant_idx+1, wrapping modulo 2**N.
  - If another request exists, computed with the new ptr and excluding the releasing index for that cycle, grant it directly next cycle (back-to-back, no IDLE bubble, grant_valid stays 1).
  - Otherwise grant_valid=0 and go to IDLE.
- Simultaneous release causes: done takes precedence over timeout, so a done arriving in the expiry cycle gives timeout=0.
- timeout pulses high for exactly one cycle, coincident with the grant_idx change or the grant_valid fall.
- grant_idx changes only when grant_valid rises or on a back-to-back handover; it never glitches mid-grant.
- Inputs:
  - Requests arriving while a grant is held wait; no preemption.
  - done while grant_valid=0 is ignored.
- Fairness: any continuously asserted request is granted within (2**N - 1) grants of any other.
- Reset mid-grant: outputs drop immediately (asynchronous); ptr returns to 0.
- Arithmetic: ptr and grant_idx wrap via N-bit truncation; the counter never overflows (saturates).

Test Plan:
- Reset with req=4'b1111, release rst_n, hold req -> grant_idx=0 valid at first edge; a done pulse each grant yields the sequence 0,1,2,3,0 back-to-back with grant_valid staying 1.
- req=4'b0100 only, no done, TIMEOUT=16 -> grant_idx=2 held 16 cycles; timeout=1 for one cycle; grant_valid falls; a regrant of 2 follows, since it is the sole requester, after one IDLE cycle.
- Granted idx=1; at cycle 5 req[1] drops with req[3]=1 -> next cycle grant_idx=3, timeout=0, grant_valid continuous.
- Owner idx=2; done asserted in the same cycle the counter hits TIMEOUT-1 -> timeout stays 0; ptr becomes 3.
- rst_n pulled low mid-grant (grant_idx=3) -> grant_valid=0, grant_idx=0 without waiting for a clock edge; after release with req=4'b1000, first grant is 3.
- done pulses while req=0 and idle -> no output change; grant_valid remains 0.

Source files
------------

// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter producing a registered binary grant index for a downstream
// one-hot decoder. Grants are held until done, owner withdrawal, or watchdog expiry.
module rr_grant_indexer #(
    parameter int N       = 2,
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2**N-1:0]  req,
    input  logic             done,
    output logic [N-1:0]     grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int NR = 2**N;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          state_reg,       state_next;
    logic [N-1:0]  ptr_reg,         ptr_next;
    logic [CW-1:0] cnt_reg,         cnt_next;
    logic [N-1:0]  grant_idx_reg,   grant_idx_next;
    logic          grant_valid_reg, grant_valid_next;
    logic          timeout_reg,     timeout_next;

    logic [N-1:0]  search_base;
    logic [NR-1:0] rot_req;
    logic [NR-1:0] cand;
    logic          cand_any;
    logic [N-1:0]  win_off;
    logic [N-1:0]  win_idx;
    logic          owner_req;
    logic          expire;
    logic          release_now;

    // While granted, the search starts just past the owner, which is the new pointer.
    assign search_base = (state_reg == ST_GRANT) ? grant_idx_reg + N'(1) : ptr_reg;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_rot
            logic [N-1:0] slot;
            assign slot        = search_base + N'(gi);
            assign rot_req[gi] = req[slot];
        end
    endgenerate

    // The last rotated slot is the releasing owner; it may not win its own handover.
    always_comb begin
        cand = rot_req;
        if (state_reg == ST_GRANT) begin
            cand[NR-1] = 1'b0;
        end
    end

    always_comb begin
        cand_any = 1'b0;
        win_off  = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_any = 1'b1;
                win_off  = i[N-1:0];
            end
        end
    end

    assign win_idx     = search_base + win_off;
    assign owner_req   = req[grant_idx_reg];
    assign expire      = (cnt_reg >= CNT_LAST);
    assign release_now = done | ~owner_req | expire;

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        cnt_next         = cnt_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        timeout_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cand_any) begin
                    grant_idx_next   = win_idx;
                    grant_valid_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = ST_GRANT;
                end
            end
            default: begin
                if (release_now) begin
                    ptr_next     = grant_idx_reg + N'(1);
                    // Only a pure watchdog expiry is reported; done or withdrawal wins.
                    timeout_next = expire & ~done & owner_req;
                    cnt_next     = '0;
                    if (cand_any) begin
                        grant_idx_next = win_idx;
                    end else begin
                        grant_valid_next = 1'b0;
                        state_next       = ST_IDLE;
                    end
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            cnt_reg         <= '0;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            cnt_reg         <= cnt_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            timeout_reg     <= timeout_next;
        end
    end

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign timeout     = timeout_reg;

endmodule
